popr_stream: RTL and testbench
==============================

// Module: popr_stream
// PURPOSE
//  Inverse of the pushr primitive: splits the first element off an input stream.
//  Head element is returned as a simple value (dOut); remaining elements are
//  forwarded unchanged, in order, on output stream sOut.
//  Sits between a stream producer and consumers in generated primitive pipelines.
//  Uses the same valid/ready stream and sync (in_valid/out_ready) conventions as
//  the other primitives.
// PARAMETERS
//  N           `intN (8)  data width of stream elements and dOut
//  SKID_DEPTH  2          sOut buffer entries; power of 2, >= 2
// PORTS
//  clk         in   1  clock; all state updates on posedge
//  rst         in   1  synchronous, active-high reset
//  in_valid    in   1  start request: pop head of sIn
//  in_ready    out  1  block can accept start request
//  out_valid   out  1  dOut holds popped head
//  out_ready   in   1  consumer takes dOut
//  sIn         in   N  input stream data
//  sIn_valid   in   1  input stream data valid
//  sIn_ready   out  1  block accepts sIn this cycle
//  dOut        out  N  popped head value
//  sOut        out  N  output stream data (tail of sIn)
//  sOut_valid  out  1  sOut valid
//  sOut_ready  in   1  downstream accepts sOut
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   state=IDLE, in_ready=1, out_valid=0, dOut=0, sIn_ready=0, sOut=0,
//   sOut_valid=0, FIFO count=0, rd/wr pointers=0. Mid-operation reset discards
//   buffered data and any un-popped head.
//  Transfers occur when valid & ready at posedge; all ready outputs are derived
//   from registered state only (no combinational valid->ready path).
//  FSM:
//   IDLE:   in_ready=1, sIn_ready=0; in_valid -> HEAD.
//   HEAD:   sIn_ready=1, in_ready=0; on sIn transfer dOut<=sIn, out_valid<=1,
//           -> STREAM. out_valid rises 1 cycle after head transfer.
//   STREAM: sIn_ready = (count < SKID_DEPTH); each sIn transfer writes FIFO.
//           sOut = FIFO[rd], sOut_valid = (count != 0). Element accepted at
//           edge k appears on sOut after edge k (1-cycle latency). Order kept.
//  out_valid holds until out_ready transfer, then clears next cycle; dOut keeps
//   its value until next head capture.
//  Full FIFO: sIn_ready=0 even if sOut_ready=1 that cycle. Push+pop in one cycle
//   (not full) leaves count unchanged. Pointers wrap modulo SKID_DEPTH.
//  Restart: in_ready=1 in STREAM only when out_valid=0 and count=0; in_valid then
//   -> HEAD, so the next sIn element becomes the new head. in_valid otherwise
//   ignored (held by requester).
//  sIn_valid low in HEAD/STREAM: stall; no state change.
// STRUCTURE
//  Shared constants in primitives.v: POPR_IDLE=2'd0, POPR_HEAD=2'd1,
//   POPR_STREAM=2'd2 state encodings.
//  One sub-module: stream_fifo #(N, SKID_DEPTH) (count, pointers, sOut mux);
//   FSM, head register and sync handshake stay in popr_stream.
// TESTING
//  1 reset, in_valid=1, sIn=5,6,7 always valid, ready high -> dOut=5,
//    out_valid 1 cycle after head transfer; sOut=6,7 in order.
//  2 sOut_ready=0 for 4 cycles after head -> count reaches 2, sIn_ready=0;
//    release -> 2 buffered values emitted first, no loss or duplication.
//  3 out_ready=0 for 3 cycles -> out_valid, dOut=5 stable; stream tail still
//    flows; in_ready stays 0.
//  4 after drain (count=0, out_valid=0) assert in_valid, next sIn=42 ->
//    dOut=42, subsequent elements on sOut.
//  5 rst pulse with 2 entries buffered and out_valid=1 -> next cycle all
//    outputs at reset values, state IDLE, in_ready=1.
//  6 sIn_valid toggling 1/0 every cycle, sOut_ready random -> sOut sequence
//    equals sIn tail; a scoreboard checks it.

Source files
------------

// File: rtl/popr_stream_pkg.sv
// Shared definitions for the popr_stream primitive: FSM state encodings and defaults.
package popr_stream_pkg;

  typedef enum logic [1:0] {
    POPR_IDLE   = 2'd0,
    POPR_HEAD   = 2'd1,
    POPR_STREAM = 2'd2
  } popr_state_e;

  localparam int POPR_DEF_N     = 8;
  localparam int POPR_DEF_DEPTH = 2;

endpackage

// File: rtl/popr_stream_fifo.sv
// Small skid FIFO carrying the stream tail; sOut is the entry at the read pointer.
module stream_fifo
  import popr_stream_pkg::*;
#(
  parameter int N     = POPR_DEF_N,
  parameter int DEPTH = POPR_DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr_en,
  input  logic [N-1:0] i_wr_data,
  input  logic         i_rd_en,
  output logic [N-1:0] o_rd_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_wr_en) begin
        r_mem[r_wr] <= i_wr_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (i_rd_en) r_rd <= r_rd + 1'b1;
      case ({i_wr_en, i_rd_en})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd];
  assign o_full    = (r_cnt == FULL_CNT);
  assign o_empty   = (r_cnt == '0);

endmodule

// File: rtl/popr_stream.sv
// Pops the head of a stream into dOut and forwards the remaining elements on sOut.
module popr_stream
  import popr_stream_pkg::*;
#(
  parameter int N          = POPR_DEF_N,
  parameter int SKID_DEPTH = POPR_DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic [N-1:0] sIn,
  input  logic         sIn_valid,
  output logic         sIn_ready,
  output logic [N-1:0] dOut,
  output logic [N-1:0] sOut,
  output logic         sOut_valid,
  input  logic         sOut_ready
);

  popr_state_e r_state, w_state_nxt;
  logic        r_out_valid;
  logic [N-1:0] r_dout;
  logic        w_head_cap, w_fifo_wr, w_fifo_rd, w_fifo_full, w_fifo_empty;

  // Readies depend only on registered state (FSM, out_valid, FIFO count).
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    sIn_ready   = 1'b0;
    w_head_cap  = 1'b0;
    w_fifo_wr   = 1'b0;
    case (r_state)
      POPR_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = POPR_HEAD;
      end
      POPR_HEAD: begin
        sIn_ready = 1'b1;
        if (sIn_valid) begin
          w_head_cap  = 1'b1;
          w_state_nxt = POPR_STREAM;
        end
      end
      POPR_STREAM: begin
        sIn_ready = ~w_fifo_full;
        w_fifo_wr = sIn_valid & ~w_fifo_full;
        // Restart only once the previous head is consumed and the tail drained.
        in_ready  = ~r_out_valid & w_fifo_empty;
        if (in_valid & in_ready) w_state_nxt = POPR_HEAD;
      end
      default: w_state_nxt = POPR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= POPR_IDLE;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_head_cap) begin
        r_dout      <= sIn;
        r_out_valid <= 1'b1;
      end else if (r_out_valid & out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign w_fifo_rd = sOut_valid & sOut_ready;

  stream_fifo #(.N(N), .DEPTH(SKID_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_fifo_wr),
    .i_wr_data (sIn),
    .i_rd_en   (w_fifo_rd),
    .o_rd_data (sOut),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  assign sOut_valid = ~w_fifo_empty;
  assign out_valid  = r_out_valid;
  assign dOut       = r_dout;

endmodule

// File: tb/tb_popr_stream.sv
// Self-checking bench for popr_stream: phase/queue reference model plus directed and random traffic.
module tb_popr_stream;

  localparam int N = 8;
  localparam int D = 2;
  localparam int P_IDLE = 0, P_HEAD = 1, P_STREAM = 2;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, sIn_valid, sOut_ready;
  logic         in_ready, out_valid, sIn_ready, sOut_valid;
  logic [N-1:0] sIn, dOut, sOut;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: stream phase, popped head, and a queue of tail elements not yet taken on sOut.
  int           m_ph;
  logic         m_ov;
  logic [N-1:0] m_dout;
  logic [N-1:0] m_q[$];
  logic         m_just_rst;
  logic [N-1:0] src[$];

  popr_stream #(.N(N), .SKID_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sIn        (sIn),
    .sIn_valid  (sIn_valid),
    .sIn_ready  (sIn_ready),
    .dOut       (dOut),
    .sOut       (sOut),
    .sOut_valid (sOut_valid),
    .sOut_ready (sOut_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_rin();
    return (m_ph == P_IDLE) || (m_ph == P_STREAM && !m_ov && m_q.size() == 0);
  endfunction

  function automatic logic m_rs();
    return (m_ph == P_HEAD) || (m_ph == P_STREAM && m_q.size() < D);
  endfunction

  task automatic check_outs();
    chk("in_ready",   32'(in_ready),   32'(m_rin()));
    chk("sIn_ready",  32'(sIn_ready),  32'(m_rs()));
    chk("out_valid",  32'(out_valid),  32'(m_ov));
    chk("dOut",       32'(dOut),       32'(m_dout));
    chk("sOut_valid", 32'(sOut_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("sOut", 32'(sOut), 32'(m_q[0]));
    else if (m_just_rst) chk("sOut_rst", 32'(sOut), 32'd0);
  endtask

  // Called at a negedge: drive inputs for the next posedge, advance the model, then check after it.
  task automatic cycle(input logic r, input logic iv, input logic orr, input logic sv, input logic sr);
    logic         sv_e, rin, rs;
    logic [N-1:0] d;
    sv_e = sv && (src.size() != 0);
    d    = (src.size() != 0) ? src[0] : '0;
    rst = r; in_valid = iv; out_ready = orr; sIn_valid = sv_e; sIn = d; sOut_ready = sr;
    rin = m_rin();
    rs  = m_rs();
    if (r) begin
      m_ph = P_IDLE; m_ov = 1'b0; m_dout = '0; m_q.delete(); m_just_rst = 1'b1;
    end else begin
      m_just_rst = 1'b0;
      if (m_q.size() != 0 && sr) void'(m_q.pop_front());
      if (m_ov && orr) m_ov = 1'b0;
      if (sv_e && rs) begin
        if (m_ph == P_HEAD) begin
          m_dout = d; m_ov = 1'b1; m_ph = P_STREAM;
        end else begin
          m_q.push_back(d);
        end
        void'(src.pop_front());
      end
      if (iv && rin) m_ph = P_HEAD;
    end
    @(negedge clk);
    check_outs();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sIn_valid = 1'b0; sIn = '0; sOut_ready = 1'b0;
    m_ph = P_IDLE; m_ov = 1'b0; m_dout = '0; m_just_rst = 1'b1;
    @(negedge clk);
    repeat (2) cycle(1, 0, 0, 0, 0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: basic pop of 5, tail 6,7
    src = '{8'd5, 8'd6, 8'd7};
    cycle(0, 1, 1, 1, 1);
    repeat (6) cycle(0, 0, 1, 1, 1);
    chk("t1_dout", 32'(dOut), 32'd5);
    chk("t1_restart_rdy", 32'(in_ready), 32'd1);

    // 2: downstream stall fills the skid buffer
    src = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14};
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 1, 1, 0);
    repeat (3) cycle(0, 0, 1, 1, 0);
    chk("t2_full_srdy", 32'(sIn_ready), 32'd0);
    chk("t2_full_sov", 32'(sOut_valid), 32'd1);
    repeat (8) cycle(0, 0, 1, 1, 1);

    // 3: head consumer stalls while the tail keeps flowing
    cycle(0, 1, 1, 0, 1);
    src = '{8'd20, 8'd21, 8'd22, 8'd23};
    cycle(0, 0, 0, 1, 1);
    repeat (3) cycle(0, 0, 0, 1, 1);
    chk("t3_dout", 32'(dOut), 32'd20);
    chk("t3_ov", 32'(out_valid), 32'd1);
    chk("t3_in_rdy", 32'(in_ready), 32'd0);
    repeat (4) cycle(0, 0, 1, 1, 1);

    // 4: restart after drain picks up a new head
    cycle(0, 1, 1, 0, 1);
    src = '{8'd42, 8'd43, 8'd44};
    repeat (5) cycle(0, 0, 1, 1, 1);
    chk("t4_dout", 32'(dOut), 32'd42);

    // 5: reset with data buffered and head pending
    cycle(0, 1, 0, 0, 0);
    src = '{8'd50, 8'd51, 8'd52, 8'd53};
    cycle(0, 0, 0, 1, 0);
    repeat (2) cycle(0, 0, 0, 1, 0);
    chk("t5_pre_ov", 32'(out_valid), 32'd1);
    chk("t5_pre_sov", 32'(sOut_valid), 32'd1);
    cycle(1, 0, 0, 0, 0);
    src.delete();
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_ov", 32'(out_valid), 32'd0);
    chk("t5_dout", 32'(dOut), 32'd0);
    chk("t5_srdy", 32'(sIn_ready), 32'd0);
    chk("t5_sout", 32'(sOut), 32'd0);
    chk("t5_sov", 32'(sOut_valid), 32'd0);

    // 6: random traffic, sIn_valid toggling every cycle
    for (int i = 0; i < 400; i++) begin
      if (src.size() == 0) src.push_back(N'($urandom));
      cycle(0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), i[0], 1'($urandom_range(0, 1)));
    end
    repeat (8) cycle(0, 0, 1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
